// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - helpers shared by the arbiter slice
package common_pkg;

  function automatic int ArbSelWidth(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  function automatic int wrap_inc(input int idx, input int entries);
    return (idx + 1 >= entries) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/selector_if.sv
// rtl/selector_if.sv - common selector interface with one-hot AND/OR data mux
interface selector_if #(
  parameter type DATA_TYPE = logic [31:0],
  parameter int  ENTRIES   = 4
);

  logic [ENTRIES-1:0] sel_onehot;
  DATA_TYPE           data [ENTRIES];
  DATA_TYPE           y;

  function automatic DATA_TYPE mux(input logic [ENTRIES-1:0] onehot,
                                   input DATA_TYPE d [ENTRIES]);
    logic [$bits(DATA_TYPE)-1:0] acc;
    acc = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      acc = acc | (d[k] & {$bits(DATA_TYPE){onehot[k]}});
    end
    return DATA_TYPE'(acc);
  endfunction

  always_comb y = mux(sel_onehot, data);

endinterface

// File: rtl/rr_grant_pick.sv
// rtl/rr_grant_pick.sv - round-robin search from ptr, wrapping at ENTRIES
module rr_grant_pick
  import common_pkg::*;
#(
  parameter int ENTRIES     = 4,
  parameter int SelectWidth = 2
) (
  input  logic [ENTRIES-1:0]     req,
  input  logic [SelectWidth-1:0] ptr,
  output logic [ENTRIES-1:0]     grant,
  output logic [SelectWidth-1:0] idx,
  output logic                   any_req
);

  int pos;

  // Walk ENTRIES positions starting at ptr; the first request seen wins.
  always_comb begin
    grant   = '0;
    idx     = '0;
    any_req = 1'b0;
    pos     = int'(ptr);
    for (int k = 0; k < ENTRIES; k++) begin
      if (!any_req && req[pos]) begin
        grant[pos] = 1'b1;
        idx        = SelectWidth'(pos);
        any_req    = 1'b1;
      end
      pos = wrap_inc(pos, ENTRIES);
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - N:1 round-robin valid/ready arbiter with registered output
module stream_rr_arbiter
  import common_pkg::*;
#(
  parameter type DATA_TYPE   = logic [31:0],
  parameter int  ENTRIES     = 4,
  localparam int SelectWidth = ArbSelWidth(ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ENTRIES-1:0]     i_valid,
  output logic [ENTRIES-1:0]     o_ready,
  input  DATA_TYPE               i_data [ENTRIES],
  output logic                   o_valid,
  input  logic                   i_ready,
  output DATA_TYPE               o_data,
  output logic [SelectWidth-1:0] o_sel
);

  logic [SelectWidth-1:0] ptr;
  logic [ENTRIES-1:0]     grant;
  logic [SelectWidth-1:0] g;
  logic                   any_req;
  logic                   load_en;

  rr_grant_pick #(
    .ENTRIES     (ENTRIES),
    .SelectWidth (SelectWidth)
  ) u_pick (
    .req     (i_valid),
    .ptr     (ptr),
    .grant   (grant),
    .idx     (g),
    .any_req (any_req)
  );

  selector_if #(.DATA_TYPE(DATA_TYPE), .ENTRIES(ENTRIES)) u_sel ();

  assign u_sel.sel_onehot = grant;
  assign u_sel.data       = i_data;

  assign load_en = !o_valid || i_ready;
  // rst_n gates ready so upstream sees no handshake while reset is held.
  assign o_ready = (load_en && rst_n) ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sel   <= '0;
      ptr     <= '0;
    end else if (load_en) begin
      if (any_req) begin
        o_valid <= 1'b1;
        o_data  <= u_sel.y;
        o_sel   <= g;
        ptr     <= SelectWidth'(wrap_inc(int'(g), ENTRIES));
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - directed self-checking bench for stream_rr_arbiter
module tb_stream_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  i_valid;
  logic [3:0]  o_ready;
  logic [31:0] i_data [4];
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic [1:0]  o_sel;

  logic [2:0]  i_valid3;
  logic [2:0]  o_ready3;
  logic [31:0] i_data3 [3];
  logic        o_valid3;
  logic        i_ready3;
  logic [31:0] o_data3;
  logic [1:0]  o_sel3;

  int n_checks;
  int n_fail;

  stream_rr_arbiter #(.DATA_TYPE(logic [31:0]), .ENTRIES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_sel   (o_sel)
  );

  stream_rr_arbiter #(.DATA_TYPE(logic [31:0]), .ENTRIES(3)) dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid3),
    .o_ready (o_ready3),
    .i_data  (i_data3),
    .o_valid (o_valid3),
    .i_ready (i_ready3),
    .o_data  (o_data3),
    .o_sel   (o_sel3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    i_valid  = 4'b0000;
    i_ready  = 1'b0;
    i_valid3 = 3'b000;
    i_ready3 = 1'b0;
    for (int k = 0; k < 4; k++) i_data[k] = 32'hA0 + k;
    for (int k = 0; k < 3; k++) i_data3[k] = 32'hB0 + k;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      #2;
      n_checks++;
      if (o_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_o_ready cycle %0d: got %b want 0000", c, o_ready);
      end
      @(posedge clk); #1;
      n_checks++;
      if (o_valid !== 1'b0 || o_sel !== 2'd0 || o_data !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got v=%b sel=%0d data=%h want v=0 sel=0 data=0",
                 c, o_valid, o_sel, o_data);
      end
    end
  endtask

  task automatic test_entries3();
    int exp_g;
    i_valid3 = 3'b111;
    i_ready3 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      exp_g = c % 3;
      #2;
      n_checks++;
      if (o_ready3 !== 3'(1 << exp_g)) begin
        n_fail++;
        $display("FAIL e3_ready step %0d: got %b want %b", c, o_ready3, 3'(1 << exp_g));
      end
      @(posedge clk); #1;
      n_checks++;
      if (o_valid3 !== 1'b1 || o_sel3 !== 2'(exp_g) || o_data3 !== 32'hB0 + exp_g) begin
        n_fail++;
        $display("FAIL e3_out step %0d: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                 c, o_valid3, o_sel3, o_data3, exp_g, 32'hB0 + exp_g);
      end
    end
    i_valid3 = 3'b000;
    @(posedge clk); #1;
  endtask

  task automatic test_all_valid();
    int exp_g;
    do_reset();
    i_valid = 4'b1111;
    i_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      exp_g = c % 4;
      #2;
      n_checks++;
      if (o_ready !== 4'(1 << exp_g)) begin
        n_fail++;
        $display("FAIL all_valid_ready step %0d: got %b want %b", c, o_ready, 4'(1 << exp_g));
      end
      @(posedge clk); #1;
      n_checks++;
      if (o_valid !== 1'b1 || o_sel !== 2'(exp_g) || o_data !== 32'hA0 + exp_g) begin
        n_fail++;
        $display("FAIL all_valid_out step %0d: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                 c, o_valid, o_sel, o_data, exp_g, 32'hA0 + exp_g);
      end
    end
    i_valid = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_sparse_wrap();
    logic [3:0] pat [5];
    int         exp_g [5];
    pat = '{4'b1010, 4'b1010, 4'b1010, 4'b0100, 4'b0001};
    exp_g = '{1, 3, 1, 2, 0};
    do_reset();
    i_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      i_valid = pat[c];
      #2;
      n_checks++;
      if (o_ready !== 4'(1 << exp_g[c])) begin
        n_fail++;
        $display("FAIL sparse_ready step %0d: got %b want %b", c, o_ready, 4'(1 << exp_g[c]));
      end
      @(posedge clk); #1;
      n_checks++;
      if (o_sel !== 2'(exp_g[c]) || o_data !== 32'hA0 + exp_g[c]) begin
        n_fail++;
        $display("FAIL sparse_out step %0d: got sel=%0d data=%h want sel=%0d data=%h",
                 c, o_sel, o_data, exp_g[c], 32'hA0 + exp_g[c]);
      end
    end
    i_valid = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    do_reset();
    i_valid = 4'b1111;
    i_ready = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (o_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL stall_ready cycle %0d: got %b want 0000", c, o_ready);
      end
      @(posedge clk); #1;
      n_checks++;
      if (o_valid !== 1'b1 || o_sel !== 2'd0 || o_data !== 32'hA0) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d: got v=%b sel=%0d data=%h want v=1 sel=0 data=a0",
                 c, o_valid, o_sel, o_data);
      end
    end
    i_ready = 1'b1;
    #1;
    n_checks++;
    if (o_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL stall_release_ready: got %b want 0010", o_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (o_valid !== 1'b1 || o_sel !== 2'd1 || o_data !== 32'hA1) begin
      n_fail++;
      $display("FAIL stall_release_out: got v=%b sel=%0d data=%h want v=1 sel=1 data=a1",
               o_valid, o_sel, o_data);
    end
    i_valid = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_fairness();
    logic [31:0] sb [$];
    int          seq [4];
    int          others_since;
    int          grants2;
    int          acc;
    int          ones;
    logic [31:0] exp_d;
    do_reset();
    for (int k = 0; k < 4; k++) seq[k] = 0;
    others_since = 0;
    grants2      = 0;
    i_valid      = 4'b0100;
    for (int c = 0; c < 200; c++) begin
      for (int k = 0; k < 4; k++) begin
        i_data[k] = {8'(k), 24'(seq[k])};
        if (k != 2 && !i_valid[k]) i_valid[k] = 1'($urandom_range(0, 1));
      end
      i_valid[2] = 1'b1;
      i_ready    = 1'($urandom_range(0, 1));
      #2;
      if (o_valid && i_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected cycle %0d: got data=%h with no pending item", c, o_data);
        end else begin
          exp_d = sb.pop_front();
          if (o_data !== exp_d) begin
            n_fail++;
            $display("FAIL sb_data cycle %0d: got %h want %h", c, o_data, exp_d);
          end
        end
      end
      acc  = -1;
      ones = 0;
      for (int k = 0; k < 4; k++) begin
        if (o_ready[k]) ones++;
        if (o_ready[k] && i_valid[k]) acc = k;
      end
      n_checks++;
      if (ones > 1) begin
        n_fail++;
        $display("FAIL onehot_ready cycle %0d: got %b want at most one bit", c, o_ready);
      end
      if (acc >= 0) begin
        sb.push_back(i_data[acc]);
        if (acc == 2) begin
          grants2++;
          n_checks++;
          if (others_since > 3) begin
            n_fail++;
            $display("FAIL fairness cycle %0d: got %0d other grants before req2 want <= 3",
                     c, others_since);
          end
          others_since = 0;
        end else begin
          others_since++;
        end
      end
      @(posedge clk); #1;
      if (acc >= 0) begin
        seq[acc]++;
        if (acc != 2) i_valid[acc] = 1'b0;
      end
    end
    i_valid = 4'b0000;
    i_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #2;
      if (o_valid) begin
        n_checks++;
        if (sb.size() == 0 || o_data !== sb[0]) begin
          n_fail++;
          $display("FAIL sb_drain step %0d: got %h want %h", c, o_data,
                   (sb.size() == 0) ? 32'hx : sb[0]);
        end
        if (sb.size() != 0) void'(sb.pop_front());
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (sb.size() != 0 || grants2 == 0) begin
      n_fail++;
      $display("FAIL sb_final: got %0d items left, %0d req2 grants want 0 left and >0 grants",
               sb.size(), grants2);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4; k++) i_data[k] = 32'hA0 + k;
    i_valid = 4'b1111;
    i_ready = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL async_preload: got v=%b want 1", o_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || o_data !== 32'h0 || o_sel !== 2'd0 || o_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b data=%h sel=%0d rdy=%b want v=0 data=0 sel=0 rdy=0000",
               o_valid, o_data, o_sel, o_ready);
    end
    i_valid = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    test_reset();
    test_entries3();
    test_all_valid();
    test_sparse_wrap();
    test_stall();
    test_fairness();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
